// File: rtl/game_pkg.sv
// Shared constants and state encoding for the whack-a-mole game controller.
package game_pkg;

  localparam int unsigned GameSecondsDef = 30;
  localparam int unsigned MoleTicksDef   = 1;
  localparam int unsigned MaxScoreDef    = 99;
  localparam int unsigned NumMoles       = 5;
  localparam int unsigned ScoreW         = 7;
  localparam int unsigned MissW          = 4;
  localparam int unsigned TimeW          = 6;
  localparam int unsigned PeriodW        = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArm  = 2'd1,
    StPlay = 2'd2,
    StDone = 2'd3
  } game_state_e;

endpackage

// File: rtl/round_timer.sv
// Round countdown: loads the round length, counts ticks down, flags the last second.
module round_timer
  import game_pkg::*;
#(
  parameter int unsigned GAME_SECONDS = GameSecondsDef
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  output logic [TimeW-1:0] time_left,
  output logic             last
);

  logic [TimeW-1:0] time_q;

  // Load wins over decrement; never wraps below zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      time_q <= '0;
    end else if (load) begin
      time_q <= TimeW'(GAME_SECONDS);
    end else if (dec && (time_q != '0)) begin
      time_q <= time_q - TimeW'(1);
    end
  end

  assign time_left = time_q;
  // The tick arriving while this is high is the one that ends the round.
  assign last      = (time_q == TimeW'(1));

endmodule

// File: rtl/game_controller.sv
// Round sequencing, hit/miss judgement and mole-change requests for whack-a-mole.
module game_controller
  import game_pkg::*;
#(
  parameter int unsigned GAME_SECONDS = GameSecondsDef,
  parameter int unsigned MOLE_TICKS   = MoleTicksDef,
  parameter int unsigned MAX_SCORE    = MaxScoreDef
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tick,
  input  logic                start_btn,
  input  logic [NumMoles-1:0] hit_btn,
  input  logic [NumMoles-1:0] mole_position,
  output logic                enable,
  output logic                pulse,
  output logic [ScoreW-1:0]   score,
  output logic [MissW-1:0]    misses,
  output logic [TimeW-1:0]    time_left,
  output logic                game_over
);

  localparam logic [ScoreW-1:0]  ScoreMax  = ScoreW'(MAX_SCORE);
  localparam logic [MissW-1:0]   MissMax   = '1;
  localparam logic [PeriodW-1:0] PeriodEnd = PeriodW'(MOLE_TICKS - 1);

  game_state_e        state_q, state_d;
  logic [ScoreW-1:0]  score_q, score_d;
  logic [MissW-1:0]   misses_q, misses_d;
  logic [PeriodW-1:0] period_q, period_d;
  logic               hit_lock_q, hit_lock_d;
  logic               pulse_q, pulse_d;
  logic               enable_q, enable_d;
  logic               game_over_q, game_over_d;

  logic               timer_load, timer_dec, timer_last;
  logic               on_target, hit, miss, expire, final_tick;

  round_timer #(
    .GAME_SECONDS(GAME_SECONDS)
  ) u_round_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (timer_load),
    .dec      (timer_dec),
    .time_left(time_left),
    .last     (timer_last)
  );

  // Next-state, scoring and pulse request; outputs are precomputed from the next state.
  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    misses_d   = misses_q;
    period_d   = period_q;
    hit_lock_d = hit_lock_q;
    pulse_d    = 1'b0;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    on_target  = 1'b0;
    hit        = 1'b0;
    miss       = 1'b0;
    expire     = 1'b0;
    final_tick = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_btn) begin
          state_d    = StArm;
          score_d    = '0;
          misses_d   = '0;
          period_d   = '0;
          hit_lock_d = 1'b0;
          timer_load = 1'b1;
          pulse_d    = 1'b1;
        end
      end
      StArm: begin
        state_d = StPlay;
      end
      StPlay: begin
        on_target  = |(hit_btn & mole_position);
        // While locked, presses are neither hits nor misses.
        hit        = on_target && !hit_lock_q;
        miss       = (|hit_btn) && !on_target && !hit_lock_q;
        final_tick = tick && timer_last;

        if (hit) begin
          score_d    = (score_q >= ScoreMax) ? ScoreMax : score_q + ScoreW'(1);
          hit_lock_d = 1'b1;
          period_d   = '0;
        end
        if (miss && (misses_q != MissMax)) begin
          misses_d = misses_q + MissW'(1);
        end
        if (tick) begin
          timer_dec = 1'b1;
          // A hit restarts the mole period, so its own tick does not advance it.
          if (!hit) begin
            if (period_q == PeriodEnd) begin
              period_d = '0;
              expire   = 1'b1;
            end else begin
              period_d = period_q + PeriodW'(1);
            end
          end
        end
        // A new mole is on its way: next-cycle presses are judged against it.
        if (pulse_q) begin
          hit_lock_d = 1'b0;
        end
        if (final_tick) begin
          state_d = StDone;
        end else begin
          // Back-to-back requests collapse; the mole already being replaced is fresh.
          pulse_d = (hit || expire) && !pulse_q;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    enable_d    = (state_d == StArm) || (state_d == StPlay);
    game_over_d = (state_d == StDone);
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      score_q     <= '0;
      misses_q    <= '0;
      period_q    <= '0;
      hit_lock_q  <= 1'b0;
      pulse_q     <= 1'b0;
      enable_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      misses_q    <= misses_d;
      period_q    <= period_d;
      hit_lock_q  <= hit_lock_d;
      pulse_q     <= pulse_d;
      enable_q    <= enable_d;
      game_over_q <= game_over_d;
    end
  end

  assign enable    = enable_q;
  assign pulse     = pulse_q;
  assign score     = score_q;
  assign misses    = misses_q;
  assign game_over = game_over_q;

endmodule
